// File: rtl/formula_result_buffer.sv
// Result buffer for the pipelined formula unit: absorbs the unit's
// unthrottled result stream into a FIFO, re-issues it on ready/valid, and
// hands out issue credits so that buffered plus in-flight results never
// exceed the FIFO depth.
module formula_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_vld,
    output logic             issue_rdy,
    input  logic             res_vld,
    input  logic [WIDTH-1:0] res,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_rdy,
    output logic             err_overflow,
    output logic             err_unexpected
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [CW-1:0]    count;
    logic [CW-1:0]    inflight;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic fire;
    logic pop;
    logic full;
    logic push;
    logic ret;
    logic [CW:0] committed;

    // Credit is computed from registers only, so a pop this cycle frees its
    // credit one cycle later.
    always_comb begin
        committed = {1'b0, count} + {1'b0, inflight};
        issue_rdy = committed < (CW + 1)'(DEPTH);
        out_vld   = (count != '0);
        out_data  = mem[rd_ptr];
        fire      = issue_vld & issue_rdy;
        pop       = out_vld & out_rdy;
        full      = (count == CW'(DEPTH));
        // A full FIFO still accepts a result when the head leaves this cycle.
        push      = res_vld & (~full | pop);
        // A result with nothing in flight is unexpected and never underflows.
        ret       = res_vld & (inflight != '0);
    end

    // Storage is deliberately not reset; out_vld qualifies the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= res;
        end
    end

    // Pointers, occupancy, in-flight tracking and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count          <= '0;
            inflight       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            err_overflow   <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({fire, ret})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            if (res_vld && full && !pop) begin
                err_overflow <= 1'b1;
            end
            if (res_vld && inflight == '0) begin
                err_unexpected <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_formula_result_buffer.sv
// Self-checking bench for formula_result_buffer (DEPTH 4, WIDTH 32).
// Expected output words go into a queue when stimulus is issued; a monitor
// pops and compares on every accepted output beat.
module tb_formula_result_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LAT   = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_vld = 1'b0;
    logic             issue_rdy;
    logic             res_vld;
    logic [WIDTH-1:0] res;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic             out_rdy = 1'b0;
    logic             err_overflow;
    logic             err_unexpected;

    logic             d_res_vld = 1'b0;
    logic [WIDTH-1:0] d_res = '0;
    logic             use_model = 1'b0;
    logic [LAT-1:0]   pv;
    logic [WIDTH-1:0] pd [LAT];
    int               fire_cnt = 0;
    int               stream_base = 0;
    int               pop_cnt = 0;
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] exp_q [$];

    formula_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_vld      (issue_vld),
        .issue_rdy      (issue_rdy),
        .res_vld        (res_vld),
        .res            (res),
        .out_vld        (out_vld),
        .out_data       (out_data),
        .out_rdy        (out_rdy),
        .err_overflow   (err_overflow),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    wire fire_tb = issue_vld & issue_rdy;

    assign res_vld = use_model ? pv[LAT-1] : d_res_vld;
    assign res     = use_model ? pd[LAT-1] : d_res;

    // Fire counter.
    always @(posedge clk) begin
        if (fire_tb) fire_cnt <= fire_cnt + 1;
    end

    // Formula-unit model: fixed latency, result k of a stream is value k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], use_model & fire_tb};
            pd[0] <= WIDTH'(fire_cnt - stream_base + 1);
            for (int i = LAT - 1; i > 0; i--) pd[i] <= pd[i-1];
            if (use_model && fire_tb) exp_q.push_back(WIDTH'(fire_cnt - stream_base + 1));
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            checks = checks + 1;
            pop_cnt = pop_cnt + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL out_data unexpected beat actual=%0d required=none", out_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors = errors + 1;
                    $display("FAIL out_data actual=%0d required=%0d", out_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, expv);
        end
    endtask

    // Asserts reset mid-cycle and checks the asynchronous values before any edge.
    task automatic do_reset();
        issue_vld = 1'b0;
        out_rdy   = 1'b0;
        d_res_vld = 1'b0;
        use_model = 1'b0;
        rst_n     = 1'b0;
        exp_q.delete();
        #2;
        chk("rst out_vld", 32'(out_vld), 0);
        chk("rst issue_rdy", 32'(issue_rdy), 1);
        chk("rst err_overflow", 32'(err_overflow), 0);
        chk("rst err_unexpected", 32'(err_unexpected), 0);
        chk("rst count", 32'(dut.count), 0);
        chk("rst inflight", 32'(dut.inflight), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_res(input logic [WIDTH-1:0] v, input bit expect_out);
        d_res_vld = 1'b1;
        d_res     = v;
        if (expect_out) exp_q.push_back(v);
        @(posedge clk); #1;
        d_res_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        out_rdy = 1'b1;
        while ((exp_q.size() != 0 || out_vld) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        out_rdy = 1'b0;
        chk({name, " drain done"}, 32'(n < 200), 1);
        chk({name, " queue empty"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int base;
        int n;
        @(posedge clk); #1;
        do_reset();

        // Credit exhaustion.
        base = fire_cnt;
        issue_vld = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        issue_vld = 1'b0;
        chk("credit fires", 32'(fire_cnt - base), 4);
        chk("credit rdy low", 32'(issue_rdy), 0);
        send_res(10, 1'b1);
        send_res(20, 1'b1);
        send_res(30, 1'b1);
        send_res(40, 1'b1);
        chk("credit out_vld", 32'(out_vld), 1);
        chk("credit rdy after return", 32'(issue_rdy), 0);
        out_rdy = 1'b1;
        #1;
        chk("credit rdy same cycle pop", 32'(issue_rdy), 0);
        @(posedge clk); #1;
        out_rdy = 1'b0;
        chk("credit rdy after pop", 32'(issue_rdy), 1);
        drain("credit");
        chk("credit errors", 32'({err_overflow, err_unexpected}), 0);

        // Streaming through the latency model with wrap-around.
        do_reset();
        stream_base = fire_cnt;
        base = pop_cnt;
        use_model = 1'b1;
        out_rdy = 1'b1;
        issue_vld = 1'b1;
        n = 0;
        while (fire_cnt - stream_base < 12 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        issue_vld = 1'b0;
        chk("stream fires", 32'(fire_cnt - stream_base), 12);
        drain("stream");
        use_model = 1'b0;
        chk("stream pops", 32'(pop_cnt - base), 12);
        chk("stream errors", 32'({err_overflow, err_unexpected}), 0);
        chk("stream wr_ptr", 32'(dut.wr_ptr), 0);
        chk("stream rd_ptr", 32'(dut.rd_ptr), 0);
        chk("stream inflight", 32'(dut.inflight), 0);

        // Simultaneous push and pop on a full FIFO.
        do_reset();
        issue_vld = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        issue_vld = 1'b0;
        send_res(7, 1'b1);
        send_res(8, 1'b1);
        send_res(9, 1'b1);
        send_res(10, 1'b1);
        chk("simul count full", 32'(dut.count), 4);
        out_rdy = 1'b1;
        send_res(11, 1'b1);
        out_rdy = 1'b0;
        chk("simul count", 32'(dut.count), 4);
        chk("simul err_overflow", 32'(err_overflow), 0);
        chk("simul head", out_data, 8);
        drain("simul");

        // Overflow detection.
        do_reset();
        send_res(1, 1'b1);
        send_res(2, 1'b1);
        send_res(3, 1'b1);
        send_res(4, 1'b1);
        chk("ovf before", 32'(err_overflow), 0);
        send_res(99, 1'b0);
        chk("ovf set", 32'(err_overflow), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf sticky", 32'(err_overflow), 1);
        drain("ovf");
        chk("ovf after drain", 32'(err_overflow), 1);
        chk("ovf empty", 32'(out_vld), 0);

        // Unexpected result.
        do_reset();
        send_res(32'h55, 1'b1);
        chk("unexp flag", 32'(err_unexpected), 1);
        chk("unexp out_vld", 32'(out_vld), 1);
        chk("unexp out_data", out_data, 32'h55);
        chk("unexp inflight", 32'(dut.inflight), 0);
        drain("unexp");
        chk("unexp sticky", 32'(err_unexpected), 1);

        // Reset asserted mid-run with state dirty: checks inside do_reset.
        issue_vld = 1'b1;
        send_res(5, 1'b0);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
